// File: rtl/running_max_tracker.sv
// Framed running-maximum tracker: feeds the external 8-bit magnitude comparator and records
// the frame maximum, the index of its first occurrence and its occurrence count.
module running_max_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] len,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] cmp_in1,
    output logic [7:0] cmp_in2,
    input  logic       cmp_eq,
    input  logic       cmp_gt,
    output logic       busy,
    output logic       done,
    output logic [7:0] max_out,
    output logic [7:0] max_idx,
    output logic [7:0] max_cnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e     state_q;
    logic [7:0] len_q;
    logic [7:0] k_q;
    logic [7:0] max_q;
    logic [7:0] idx_q;
    logic [7:0] cnt_q;
    logic       in_ready_q;
    logic       busy_q;
    logic       done_q;

    logic       accept;
    logic       last_accept;
    logic [7:0] len_m1;

    // Comparator operands are pure wiring; its result returns within the same cycle.
    assign cmp_in1 = in_data;
    assign cmp_in2 = max_q;

    always_comb begin
        len_m1      = len_q - 8'd1;
        accept      = (state_q == StAccum) && in_valid;
        last_accept = accept && (k_q == len_m1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= 8'd0;
            k_q        <= 8'd0;
            max_q      <= 8'd0;
            idx_q      <= 8'd0;
            cnt_q      <= 8'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q <= len;
                        k_q   <= 8'd0;
                        max_q <= 8'd0;
                        idx_q <= 8'd0;
                        cnt_q <= 8'd0;
                        busy_q <= 1'b1;
                        if (len == 8'd0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= StAccum;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StAccum: begin
                    if (accept) begin
                        k_q <= k_q + 8'd1;
                        // First sample seeds the max; the comparator is still looking at the
                        // cleared register and its verdict is meaningless here.
                        if (k_q == 8'd0) begin
                            max_q <= in_data;
                            idx_q <= 8'd0;
                            cnt_q <= 8'd1;
                        end else if (cmp_gt) begin
                            max_q <= in_data;
                            idx_q <= k_q;
                            cnt_q <= 8'd1;
                        end else if (cmp_eq) begin
                            if (cnt_q != 8'hFF) begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        if (last_accept) begin
                            state_q    <= StDone;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign max_out  = max_q;
    assign max_idx  = idx_q;
    assign max_cnt  = cnt_q;

endmodule

// File: tb/tb_running_max_tracker.sv
// Bench for running_max_tracker: directed and random frames, frame results checked by a
// done-triggered scoreboard monitor against a plain reference model.
module tb_running_max_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] cmp_in1;
    logic [7:0] cmp_in2;
    logic       cmp_eq;
    logic       cmp_gt;
    logic       busy;
    logic       done;
    logic [7:0] max_out;
    logic [7:0] max_idx;
    logic [7:0] max_cnt;

    typedef struct packed {
        logic [7:0] mx;
        logic [7:0] idx;
        logic [7:0] cnt;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [7:0] stim[$];
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    // Upstream magnitude comparator.
    assign cmp_eq = (cmp_in1 == cmp_in2);
    assign cmp_gt = (cmp_in1 > cmp_in2);

    running_max_tracker dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cmp_in1  (cmp_in1),
        .cmp_in2  (cmp_in2),
        .cmp_eq   (cmp_eq),
        .cmp_gt   (cmp_gt),
        .busy     (busy),
        .done     (done),
        .max_out  (max_out),
        .max_idx  (max_idx),
        .max_cnt  (max_cnt)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: max over the frame, first position holding it, occurrences capped at 255.
    function automatic exp_t model_frame();
        exp_t e;
        int   n;
        e = '0;
        if (stim.size() == 0) return e;
        foreach (stim[i]) if (stim[i] > e.mx) e.mx = stim[i];
        n = 0;
        for (int i = stim.size() - 1; i >= 0; i--) begin
            if (stim[i] == e.mx) begin
                e.idx = 8'(i);
                n++;
            end
        end
        e.cnt = (n > 255) ? 8'd255 : 8'(n);
        return e;
    endfunction

    // Scoreboard monitor: every done pulse consumes one expected frame result.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("done_single_cycle", int'(done_prev), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("max_out", int'(max_out), int'(e.mx));
                check("max_idx", int'(max_idx), int'(e.idx));
                check("max_cnt", int'(max_cnt), int'(e.cnt));
                check("busy_in_done", int'(busy), 1);
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic run_frame(input int gap_pct, input bit noise);
        exp_t e;
        e = model_frame();
        wait_idle();
        if (noise) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
            tick();
            check("idle_valid_ignored", int'(busy), 0);
            in_valid = 1'b0;
        end
        exp_q.push_back(e);
        start = 1'b1;
        len   = 8'(stim.size());
        tick();
        start = 1'b0;
        if (stim.size() == 0) begin
            check("len0_done", int'(done), 1);
        end else begin
            check("in_ready_after_start", int'(in_ready), 1);
            foreach (stim[i]) begin
                while ($urandom_range(0, 99) < gap_pct) begin
                    in_valid = 1'b0;
                    if (noise) begin
                        start = 1'b1;
                        len   = 8'($urandom);
                    end
                    tick();
                    start = 1'b0;
                end
                in_valid = 1'b1;
                in_data  = stim[i];
                tick();
            end
            in_valid = 1'b0;
            check("done_after_last", int'(done), 1);
            check("in_ready_in_done", int'(in_ready), 0);
        end
        tick();
        check("busy_after_done", int'(busy), 0);
        check("done_after_done", int'(done), 0);
        check("hold_max_out", int'(max_out), int'(e.mx));
        check("hold_max_cnt", int'(max_cnt), int'(e.cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = 8'd0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_max_out", int'(max_out), 0);
        check("rst_max_idx", int'(max_idx), 0);
        check("rst_max_cnt", int'(max_cnt), 0);
        rst = 1'b0;
        tick();

        // Abort a frame mid-way with reset.
        start = 1'b1;
        len   = 8'd4;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h50;
        tick();
        in_data = 8'h60;
        tick();
        check("mid_pre_rst_max", int'(max_out), 'h60);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_max_out", int'(max_out), 0);
        check("mid_rst_max_idx", int'(max_idx), 0);
        check("mid_rst_max_cnt", int'(max_cnt), 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        stim = {8'h10};
        run_frame(0, 1'b0);
        stim = {8'h03, 8'h7F, 8'h20, 8'h80, 8'h01};
        run_frame(0, 1'b0);
        stim = {8'h55, 8'h55, 8'h10, 8'h55, 8'hAA, 8'hAA};
        run_frame(0, 1'b0);
        run_frame(50, 1'b1);
        stim = {8'h00, 8'h00, 8'h00};
        run_frame(0, 1'b0);
        stim.delete();
        run_frame(0, 1'b0);
        repeat (255) stim.push_back(8'hFF);
        run_frame(0, 1'b0);
        stim = {8'h00};
        run_frame(0, 1'b0);

        repeat (30) begin
            int n;
            int sh;
            stim.delete();
            n  = $urandom_range(0, 24);
            sh = $urandom_range(0, 5);
            repeat (n) stim.push_back(8'($urandom_range(0, 7) << sh));
            run_frame($urandom_range(0, 60), 1'($urandom_range(0, 1)));
        end

        tick();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
